// File: rtl/cga_mac_pkg.sv
// Shared encodings for the CGA MAC segment/PCR readback block:
// read-select codes, FSM state encoding, STAT word bit positions
// and a helper that packs the STAT word.
package cga_mac_pkg;

  // Read-select encodings
  localparam logic [1:0] RDSEL_PCR  = 2'b00;
  localparam logic [1:0] RDSEL_SEG  = 2'b01;
  localparam logic [1:0] RDSEL_STAT = 2'b10;
  localparam logic [1:0] RDSEL_DUMP = 2'b11;

  // Readback FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_DUMP = 2'b10,
    ST_DONE = 2'b11
  } rdbk_state_t;

  // STAT word bit positions
  localparam int STAT_XPT_LSB  = 0;
  localparam int STAT_PEX_BIT  = 2;
  localparam int STAT_VEX_BIT  = 3;
  localparam int STAT_SEGN_BIT = 4;

  // Dump word indices
  localparam logic [1:0] IDX_PCR  = 2'd0;
  localparam logic [1:0] IDX_SEG  = 2'd1;
  localparam logic [1:0] IDX_STAT = 2'd2;

  // Pack the status bits into the 16-bit STAT word; SEGZN is inverted
  function automatic logic [15:0] pack_stat(input logic [1:0] xpt,
                                            input logic       pex,
                                            input logic       vex,
                                            input logic       segzn);
    logic [15:0] w;
    w = 16'h0000;
    w[STAT_XPT_LSB +: 2] = xpt;
    w[STAT_PEX_BIT]      = pex;
    w[STAT_VEX_BIT]      = vex;
    w[STAT_SEGN_BIT]     = ~segzn;
    return w;
  endfunction

endpackage

// File: rtl/cga_mac_segpt_rdbk_fmt.sv
// Combinational word formatter: builds the PCR, SEG and STAT words
// from the live register inputs and selects one of them by RDSEL.
module cga_mac_segpt_rdbk_fmt
  import cga_mac_pkg::*;
(
  input  logic [15:0] pcr,
  input  logic [7:0]  seg,
  input  logic [1:0]  xpt,
  input  logic        pex,
  input  logic        vex,
  input  logic        segzn,
  input  logic [1:0]  sel,
  output logic [15:0] pcr_word,
  output logic [15:0] seg_word,
  output logic [15:0] stat_word,
  output logic [15:0] sel_word
);

  // Format each word from the live inputs
  always_comb begin
    pcr_word  = pcr;
    seg_word  = {8'h00, seg};
    stat_word = pack_stat(xpt, pex, vex, segzn);
  end

  // Select the word for a single read; DUMP starts with the PCR word
  always_comb begin
    sel_word = 16'h0000;
    case (sel)
      RDSEL_PCR:  sel_word = pcr_word;
      RDSEL_SEG:  sel_word = seg_word;
      RDSEL_STAT: sel_word = stat_word;
      RDSEL_DUMP: sel_word = pcr_word;
      default:    sel_word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/cga_mac_segpt_rdbk.sv
// Readback engine for the CGA MAC segment/PCR registers. A single read
// snapshots one word and holds it until acknowledged; a DUMP snapshots
// all three words on one edge and streams PCR, SEG, STAT with no bubble
// while IDBACK is held, then pulses DUMPDONE. All outputs are registered.
module cga_mac_segpt_rdbk
  import cga_mac_pkg::*;
(
  input  logic        MCLK,
  input  logic        BRESETN,
  input  logic [15:0] PCR_15_0,
  input  logic [7:0]  SEG_7_0,
  input  logic [1:0]  XPT_1_0,
  input  logic        PEX,
  input  logic        VEX,
  input  logic        SEGZN,
  input  logic        RDREQ,
  input  logic [1:0]  RDSEL_1_0,
  input  logic        IDBACK,
  output logic [15:0] IDBO_15_0,
  output logic        IDBVALID,
  output logic        BUSY,
  output logic        DUMPDONE
);

  rdbk_state_t state_r;
  logic [1:0]  idx_r;
  logic [15:0] idbo_r;
  logic        idbvalid_r;
  logic        busy_r;
  logic        dumpdone_r;
  logic [15:0] pcr_snap_r;
  logic [15:0] seg_snap_r;
  logic [15:0] stat_snap_r;

  logic [15:0] pcr_word_s;
  logic [15:0] seg_word_s;
  logic [15:0] stat_word_s;
  logic [15:0] sel_word_s;

  cga_mac_segpt_rdbk_fmt u_fmt (
    .pcr       (PCR_15_0),
    .seg       (SEG_7_0),
    .xpt       (XPT_1_0),
    .pex       (PEX),
    .vex       (VEX),
    .segzn     (SEGZN),
    .sel       (RDSEL_1_0),
    .pcr_word  (pcr_word_s),
    .seg_word  (seg_word_s),
    .stat_word (stat_word_s),
    .sel_word  (sel_word_s)
  );

  // Readback FSM with index counter, snapshots and registered outputs
  always_ff @(posedge MCLK or negedge BRESETN) begin
    if (!BRESETN) begin
      state_r     <= ST_IDLE;
      idx_r       <= IDX_PCR;
      idbo_r      <= 16'h0000;
      idbvalid_r  <= 1'b0;
      busy_r      <= 1'b0;
      dumpdone_r  <= 1'b0;
      pcr_snap_r  <= 16'h0000;
      seg_snap_r  <= 16'h0000;
      stat_snap_r <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          dumpdone_r <= 1'b0;
          idx_r      <= IDX_PCR;
          if (RDREQ) begin
            idbvalid_r <= 1'b1;
            busy_r     <= 1'b1;
            if (RDSEL_1_0 == RDSEL_DUMP) begin
              // All three words are captured on the same edge
              pcr_snap_r  <= pcr_word_s;
              seg_snap_r  <= seg_word_s;
              stat_snap_r <= stat_word_s;
              idbo_r      <= pcr_word_s;
              state_r     <= ST_DUMP;
            end else begin
              idbo_r  <= sel_word_s;
              state_r <= ST_HOLD;
            end
          end else begin
            idbvalid_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        end

        ST_HOLD: begin
          dumpdone_r <= 1'b0;
          if (IDBACK) begin
            idbvalid_r <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            idbvalid_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end

        ST_DUMP: begin
          if (idx_r == 2'd3) begin
            // Illegal index: abandon the dump quietly
            idx_r      <= IDX_PCR;
            idbvalid_r <= 1'b0;
            busy_r     <= 1'b0;
            dumpdone_r <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (IDBACK) begin
            case (idx_r)
              IDX_PCR: begin
                idx_r  <= IDX_SEG;
                idbo_r <= seg_snap_r;
              end
              IDX_SEG: begin
                idx_r  <= IDX_STAT;
                idbo_r <= stat_snap_r;
              end
              IDX_STAT: begin
                idx_r      <= IDX_PCR;
                idbvalid_r <= 1'b0;
                dumpdone_r <= 1'b1;
                state_r    <= ST_DONE;
              end
              default: begin
                idx_r      <= IDX_PCR;
                idbvalid_r <= 1'b0;
                busy_r     <= 1'b0;
                state_r    <= ST_IDLE;
              end
            endcase
          end else begin
            idbvalid_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end

        ST_DONE: begin
          dumpdone_r <= 1'b0;
          idbvalid_r <= 1'b0;
          busy_r     <= 1'b0;
          idx_r      <= IDX_PCR;
          state_r    <= ST_IDLE;
        end

        default: begin
          idx_r      <= IDX_PCR;
          idbvalid_r <= 1'b0;
          busy_r     <= 1'b0;
          dumpdone_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign IDBO_15_0 = idbo_r;
  assign IDBVALID  = idbvalid_r;
  assign BUSY      = busy_r;
  assign DUMPDONE  = dumpdone_r;

endmodule

// File: doc/cga_mac_segpt_rdbk.md
CGA_MAC_SEGPT_RDBK -- requirements
Module: cga_mac_segpt_rdbk

Interface
REQ-001 SHALL have port MCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port BRESETN, input, 1 bit: the only reset; asynchronous, active-low.
REQ-003 SHALL have port PCR_15_0, input, 16 bits: live PCR register value.
REQ-004 SHALL have port SEG_7_0, input, 8 bits: live segment register value.
REQ-005 SHALL have ports XPT_1_0 (input, 2 bits), PEX (input, 1), VEX (input, 1) and SEGZN (input, 1): live XPT and status bits.
REQ-006 SHALL have port RDREQ, input, 1 bit: read request, sampled only in IDLE.
REQ-007 SHALL have port RDSEL_1_0, input, 2 bits: read select; 00 = PCR, 01 = SEG, 10 = STAT, 11 = DUMP.
REQ-008 SHALL have port IDBACK, input, 1 bit: consumer accepts the current word.
REQ-009 SHALL have port IDBO_15_0, output, 16 bits: readback word.
REQ-010 SHALL have port IDBVALID, output, 1 bit: IDBO_15_0 holds a valid word.
REQ-011 SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port DUMPDONE, output, 1 bit: one-cycle pulse after the last DUMP word is accepted.

Function
REQ-013 Word formats SHALL be: PCR word = PCR_15_0; SEG word = {8'h00, SEG_7_0}; STAT word = {11'b0, ~SEGZN, VEX, PEX, XPT_1_0}.
REQ-014 SHALL implement an FSM with states IDLE, HOLD, DUMP and DONE.
REQ-015 IDLE: on RDREQ=1 with RDSEL 00, 01 or 10, SHALL snapshot the selected word into the output register and go to HOLD; IDBVALID rises on the next cycle (latency 1).
REQ-016 IDLE: on RDREQ=1 with RDSEL=11, SHALL snapshot all three words in the same edge, load word index 0 (PCR) onto IDBO and go to DUMP.
REQ-017 HOLD: IDBVALID=1 and IDBO stable until an edge with IDBACK=1, after which the FSM SHALL go to IDLE with IDBVALID=0.
REQ-018 DUMP: words SHALL be presented in the order PCR, SEG, STAT using a 2-bit index; each edge with IDBACK=1 advances the index, and the next word SHALL be valid in the immediately following cycle with no bubble.
REQ-019 DUMP: IDBACK=1 at index 2 SHALL move the FSM to DONE; DONE asserts DUMPDONE=1 and IDBVALID=0 for exactly one cycle, then goes to IDLE.
REQ-020 Snapshotted words SHALL NOT change while BUSY, even if the PCR, SEG, XPT or status inputs change.
REQ-021 RDREQ while BUSY SHALL be ignored and not queued; in IDLE, a request is accepted in the same cycle that BUSY falls.
REQ-022 IDBACK with IDBVALID=0 SHALL be ignored.
REQ-023 The 2-bit index SHALL never reach 3; an index value of 3 is unreachable and forces IDLE.
REQ-024 IDBO_15_0 SHALL hold its last value when IDBVALID=0; consumers qualify it with IDBVALID.

Reset
REQ-025 BRESETN=0 SHALL immediately force: state IDLE, index 0, IDBO_15_0=16'h0000, IDBVALID=0, BUSY=0, DUMPDONE=0 and all snapshots 0.
REQ-026 Reset asserted mid-HOLD or mid-DUMP SHALL abort the transfer; no DUMPDONE pulse is produced.

Structure
REQ-027 The RDSEL encodings, FSM state encodings and STAT bit positions SHALL live in shared package cga_mac_pkg.
REQ-028 The word-format mux SHALL be a combinational sub-module cga_mac_segpt_rdbk_fmt; the FSM, index counter and registers stay in the top module.

Verification
REQ-029 The bench SHALL cover the PCR read: PCR=16'hA5C3, RDREQ with RDSEL=00 -> IDBO=16'hA5C3 with IDBVALID=1 one cycle later; hold IDBACK=0 for 5 cycles -> word stable; IDBACK=1 -> IDBVALID=0 and BUSY=0.
REQ-030 The bench SHALL cover the STAT format: XPT=2'b10, PEX=1, VEX=0, SEGZN=0 -> STAT word 16'h0016.
REQ-031 The bench SHALL cover a back-to-back DUMP: PCR=16'h1234, SEG=8'h7F, IDBACK held at 1 -> 16'h1234, 16'h007F, STAT on consecutive cycles, then DUMPDONE pulses for 1 cycle.
REQ-032 The bench SHALL cover snapshot integrity: start DUMP, change PCR to 16'hFFFF before the first ack -> first word is still the old PCR.
REQ-033 The bench SHALL cover a request while busy: RDREQ with RDSEL=01 during HOLD -> ignored, and no second word appears after the ack.
REQ-034 The bench SHALL cover reset mid-DUMP: drop BRESETN at index 1 -> outputs go to 0 asynchronously, no DUMPDONE pulse, and the FSM is in IDLE after release.
